// File: rtl/up_dn_cmd_pkg.sv
// Shared types and constants for the up/down counter command generator.
package up_dn_cmd_pkg;

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer for one raw button.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic deb_o
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  // Count cycles of disagreement; the level flips once the run is long enough.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/up_dn_cmd_gen.sv
// Button-to-command front end for the 5-bit up/down counter.
// Define UP_DN_CMD_REPEAT_EN to build the DELAY/REPEAT auto-repeat path.
module up_dn_cmd_gen
  import up_dn_cmd_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Btn_Up,
  input  logic             Btn_Dn,
  input  logic             Btn_Ld,
  input  logic [CNT_W-1:0] Preset,
  input  logic             High,
  input  logic             Low,
  output logic             Up,
  output logic             Down,
  output logic             Load,
  output logic [CNT_W-1:0] IN
);

  logic             deb_up, deb_dn, deb_ld;
  logic             deb_up_q, deb_dn_q, deb_ld_q;
  logic             rise_up, rise_dn, rise_ld;
  logic             act_deb;
  logic             fire;
  dir_e             fire_dir;
  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic             up_q, up_d, down_q, down_d, load_q, load_d;
  logic [CNT_W-1:0] in_q, in_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk_i(Clk), .rst_n_i(Rst_n), .btn_i(Btn_Up), .deb_o(deb_up)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk_i(Clk), .rst_n_i(Rst_n), .btn_i(Btn_Dn), .deb_o(deb_dn)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ld (
    .clk_i(Clk), .rst_n_i(Rst_n), .btn_i(Btn_Ld), .deb_o(deb_ld)
  );

  assign rise_up = deb_up & ~deb_up_q;
  assign rise_dn = deb_dn & ~deb_dn_q;
  assign rise_ld = deb_ld & ~deb_ld_q;
  assign act_deb = (dir_q == DIR_UP) ? deb_up : deb_dn;

`ifdef UP_DN_CMD_REPEAT_EN
  localparam int unsigned       TMR_MAX    = max_u(REPEAT_DELAY, REPEAT_RATE);
  localparam int unsigned       TMR_W      = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0]  DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0]  RATE_LAST  = TMR_W'(REPEAT_RATE - 1);
  localparam state_e            PRESS_ST   = DELAY;

  logic             opp_deb;
  logic [TMR_W-1:0] timer_q, timer_d;

  assign opp_deb = (dir_q == DIR_UP) ? deb_dn : deb_up;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  localparam state_e PRESS_ST = HELD;

  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  // Load preempts the direction FSM; fires are masked at the counter limits.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    up_d     = 1'b0;
    down_d   = 1'b0;
    load_d   = 1'b0;
    in_d     = in_q;
    fire     = 1'b0;
    fire_dir = dir_q;
`ifdef UP_DN_CMD_REPEAT_EN
    timer_d  = timer_q;
`endif
    if (rise_ld) begin
      load_d  = 1'b1;
      in_d    = Preset;
      state_d = IDLE;
`ifdef UP_DN_CMD_REPEAT_EN
      timer_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef UP_DN_CMD_REPEAT_EN
          timer_d = '0;
`endif
          if (rise_up && !deb_dn) begin
            fire     = 1'b1;
            fire_dir = DIR_UP;
          end else if (rise_dn && !deb_up) begin
            fire     = 1'b1;
            fire_dir = DIR_DN;
          end
          if (fire) begin
            dir_d   = fire_dir;
            state_d = PRESS_ST;
          end
        end
`ifdef UP_DN_CMD_REPEAT_EN
        DELAY: begin
          if (!act_deb || opp_deb) begin
            state_d = IDLE;
          end else if (timer_q == DELAY_LAST) begin
            fire    = 1'b1;
            state_d = REPEAT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        REPEAT: begin
          if (!act_deb || opp_deb) begin
            state_d = IDLE;
          end else if (timer_q == RATE_LAST) begin
            fire    = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
`else
        HELD: begin
          if (!act_deb) begin
            state_d = IDLE;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
    if (fire) begin
      up_d   = (fire_dir == DIR_UP) && !High;
      down_d = (fire_dir == DIR_DN) && !Low;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      deb_up_q <= 1'b0;
      deb_dn_q <= 1'b0;
      deb_ld_q <= 1'b0;
      state_q  <= IDLE;
      dir_q    <= DIR_UP;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      load_q   <= 1'b0;
      in_q     <= '0;
    end else begin
      deb_up_q <= deb_up;
      deb_dn_q <= deb_dn;
      deb_ld_q <= deb_ld;
      state_q  <= state_d;
      dir_q    <= dir_d;
      up_q     <= up_d;
      down_q   <= down_d;
      load_q   <= load_d;
      in_q     <= in_d;
    end
  end

  assign Up   = up_q;
  assign Down = down_q;
  assign Load = load_q;
  assign IN   = in_q;

endmodule
